// File: rtl/consumer_request_queue_if.sv
// consumer_request_queue_if: consumer push ports and scheduler grant/request ports for the per-consumer queues
interface consumer_request_queue_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 2,
    parameter int DEPTH       = 4
);
    localparam int REQ_WIDTH = ADDR_WIDTH + VALUE_WIDTH + 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    logic [NCONSUMERS-1:0]                  push_valid;
    logic [NCONSUMERS-1:0][ADDR_WIDTH-1:0]  push_addr;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] push_value;
    logic [NCONSUMERS-1:0]                  push_ready;
    logic [NCONSUMERS-1:0][REQ_WIDTH-1:0]   requests;
    logic [NCONSUMERS-1:0]                  grant;
    logic [NCONSUMERS-1:0][CNT_WIDTH-1:0]   occupancy;
    modport master (
        output push_valid, push_addr, push_value, grant,
        input  push_ready, requests, occupancy
    );
    modport slave (
        input  push_valid, push_addr, push_value, grant,
        output push_ready, requests, occupancy
    );
endinterface

// File: rtl/consumer_request_queue.sv
// consumer_request_queue: independent per-consumer FIFOs whose heads feed the round-robin scheduler
module consumer_request_queue #(
    parameter int ADDR_WIDTH  = 4,
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 2,
    parameter int DEPTH       = 4
) (
    input logic clk,
    input logic reset,
    consumer_request_queue_if.slave bus
);
    localparam int CNT_WIDTH   = $clog2(DEPTH + 1);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int ENTRY_WIDTH = ADDR_WIDTH + VALUE_WIDTH;
    genvar i;
    for (i = 0; i < NCONSUMERS; i++) begin : g_q
        logic [ENTRY_WIDTH-1:0] mem [DEPTH];
        logic [PTR_WIDTH-1:0]   rd_ptr, wr_ptr;
        logic [CNT_WIDTH-1:0]   count;
        logic                   ready, push, pop;
        // ready comes from registered count only, so a pop cannot free a slot for a same-cycle push
        assign ready = count != CNT_WIDTH'(DEPTH);
        assign push  = bus.push_valid[i] && ready;
        assign pop   = bus.grant[i] && (count != '0);
        assign bus.push_ready[i] = ready;
        assign bus.occupancy[i]  = count;
        assign bus.requests[i]   = (count != '0) ? {1'b1, mem[rd_ptr]} : '0;
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(pop);
                wr_ptr <= wr_ptr + PTR_WIDTH'(push);
                count  <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            end
        end
        always_ff @(posedge clk) begin
            if (push && !reset) mem[wr_ptr] <= {bus.push_addr[i], bus.push_value[i]};
        end
    end
endmodule
